alu_decode_unit: RTL and testbench

Registered execute-stage decode and ALU block for the single-cycle MIPS datapath. It decodes the 6-bit opcode into main control signals and a 2-bit ALU operation class. It resolves that class together with the R-type function field into a 4-bit ALU control code, then computes the 32-bit ALU result and zero flag. All outputs are registered, giving one clock of latency.

---
 rtl/alu_decode_unit_if.sv | 37 +++
 rtl/alu_decode_unit.sv | 145 ++++++++++++++
 tb/tb_alu_decode_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_unit_if.sv
// Bus between the execute-stage decode/ALU block and its surroundings.
// The master drives the instruction fields and operands. The slave returns the registered controls and ALU result.
interface alu_decode_unit_if #(
   parameter int WIDTH = 32
);
   logic             valid_in;
   logic [5:0]       opcode;
   logic [5:0]       func;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;

   logic             valid_out;
   logic             reg_dst;
   logic             jump;
   logic             branch;
   logic             mem_read;
   logic             mem_to_reg;
   logic             mem_write;
   logic             alu_src;
   logic             reg_write;
   logic [1:0]       alu_op;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_result;
   logic             zero;

   modport master (
      output valid_in, opcode, func, src_a, src_b,
      input  valid_out, reg_dst, jump, branch, mem_read, mem_to_reg,
             mem_write, alu_src, reg_write, alu_op, alu_ctrl, alu_result, zero
   );

   modport slave (
      input  valid_in, opcode, func, src_a, src_b,
      output valid_out, reg_dst, jump, branch, mem_read, mem_to_reg,
             mem_write, alu_src, reg_write, alu_op, alu_ctrl, alu_result, zero
   );
endinterface

// File: rtl/alu_decode_unit.sv
// Registered MIPS main decode, ALU control and ALU. It has one cycle of latency.
// When ALU_SHIFT_EN is defined, sll/srl are decoded and a shifter is built.
module alu_decode_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   alu_decode_unit_if.slave   bus
);

   logic             regDst_d, jump_d, branch_d, memRead_d, memToReg_d;
   logic             memWrite_d, aluSrc_d, regWrite_d;
   logic [1:0]       aluOp_d;
   logic [3:0]       aluCtrl_d;
   logic [WIDTH-1:0] result_d;
   logic             zero_d;

   logic             validOut_q;
   logic             regDst_q, jump_q, branch_q, memRead_q, memToReg_q;
   logic             memWrite_q, aluSrc_q, regWrite_q;
   logic [1:0]       aluOp_q;
   logic [3:0]       aluCtrl_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;

   always_comb begin
      regDst_d   = 1'b0;
      jump_d     = 1'b0;
      branch_d   = 1'b0;
      memRead_d  = 1'b0;
      memToReg_d = 1'b0;
      memWrite_d = 1'b0;
      aluSrc_d   = 1'b0;
      regWrite_d = 1'b0;
      aluOp_d    = 2'b11;
      unique case (bus.opcode)
         6'b000000: begin regDst_d = 1'b1; regWrite_d = 1'b1; aluOp_d = 2'b10; end
         6'b100011: begin
            aluSrc_d   = 1'b1;
            memToReg_d = 1'b1;
            regWrite_d = 1'b1;
            memRead_d  = 1'b1;
            aluOp_d    = 2'b00;
         end
         6'b101011: begin aluSrc_d = 1'b1; memWrite_d = 1'b1; aluOp_d = 2'b00; end
         6'b000100: begin branch_d = 1'b1; aluOp_d = 2'b01; end
         6'b001000: begin aluSrc_d = 1'b1; regWrite_d = 1'b1; aluOp_d = 2'b00; end
         6'b000010: begin jump_d = 1'b1; aluOp_d = 2'b00; end
         default:   aluOp_d = 2'b11;
      endcase
   end

   always_comb begin
      aluCtrl_d = 4'b1111;
      unique case (aluOp_d)
         2'b00: aluCtrl_d = 4'b0010;
         2'b01: aluCtrl_d = 4'b0110;
         2'b10: begin
            unique case (bus.func)
               6'b100000: aluCtrl_d = 4'b0010;
               6'b100010: aluCtrl_d = 4'b0110;
               6'b100100: aluCtrl_d = 4'b0000;
               6'b100101: aluCtrl_d = 4'b0001;
               6'b100111: aluCtrl_d = 4'b1100;
               6'b101010: aluCtrl_d = 4'b0111;
`ifdef ALU_SHIFT_EN
               6'b000000: aluCtrl_d = 4'b0011;
               6'b000010: aluCtrl_d = 4'b0100;
`endif
               default:   aluCtrl_d = 4'b1111;
            endcase
         end
         default: aluCtrl_d = 4'b1111;
      endcase
   end

   // Operands are used exactly as given; the immediate/register mux lives outside this block.
   always_comb begin
      result_d = '0;
      unique case (aluCtrl_d)
         4'b0010: result_d = bus.src_a + bus.src_b;
         4'b0110: result_d = bus.src_a - bus.src_b;
         4'b0000: result_d = bus.src_a & bus.src_b;
         4'b0001: result_d = bus.src_a | bus.src_b;
         4'b1100: result_d = ~(bus.src_a | bus.src_b);
         4'b0111: result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
`ifdef ALU_SHIFT_EN
         4'b0011: result_d = bus.src_a << bus.src_b[4:0];
         4'b0100: result_d = bus.src_a >> bus.src_b[4:0];
`endif
         default: result_d = '0;
      endcase
      zero_d = (result_d == '0);
   end

   // valid_out tracks valid_in every cycle. All other state holds unless valid_in is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         validOut_q <= 1'b0;
         regDst_q   <= 1'b0;
         jump_q     <= 1'b0;
         branch_q   <= 1'b0;
         memRead_q  <= 1'b0;
         memToReg_q <= 1'b0;
         memWrite_q <= 1'b0;
         aluSrc_q   <= 1'b0;
         regWrite_q <= 1'b0;
         aluOp_q    <= 2'b00;
         aluCtrl_q  <= 4'b0000;
         result_q   <= '0;
         zero_q     <= 1'b0;
      end else begin
         validOut_q <= bus.valid_in;
         if (bus.valid_in) begin
            regDst_q   <= regDst_d;
            jump_q     <= jump_d;
            branch_q   <= branch_d;
            memRead_q  <= memRead_d;
            memToReg_q <= memToReg_d;
            memWrite_q <= memWrite_d;
            aluSrc_q   <= aluSrc_d;
            regWrite_q <= regWrite_d;
            aluOp_q    <= aluOp_d;
            aluCtrl_q  <= aluCtrl_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
         end
      end
   end

   assign bus.valid_out  = validOut_q;
   assign bus.reg_dst    = regDst_q;
   assign bus.jump       = jump_q;
   assign bus.branch     = branch_q;
   assign bus.mem_read   = memRead_q;
   assign bus.mem_to_reg = memToReg_q;
   assign bus.mem_write  = memWrite_q;
   assign bus.alu_src    = aluSrc_q;
   assign bus.reg_write  = regWrite_q;
   assign bus.alu_op     = aluOp_q;
   assign bus.alu_ctrl   = aluCtrl_q;
   assign bus.alu_result = result_q;
   assign bus.zero       = zero_q;

endmodule

// File: tb/tb_alu_decode_unit.sv
// Scoreboard bench for alu_decode_unit. It uses directed cases followed by randomized traffic.
// A reference model predicts each registered output. A monitor compares the DUT outputs one cycle later.
module tb_alu_decode_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_decode_unit_if #(.WIDTH(32)) bus ();
   alu_decode_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic        valid;
      logic        regDst, jump, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
      logic [1:0]  aluOp;
      logic [3:0]  aluCtrl;
      logic [31:0] result;
      logic        zero;
   } outs_t;

   typedef struct {
      outs_t exp;
      string tag;
   } entry_t;

   entry_t scoreQ[$];
   outs_t  lastOut;
   int     testsRun = 0;
   int     testsFailed = 0;

   // Reference model: instruction semantics expressed directly as tables and arithmetic.
   function automatic outs_t refModel(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [31:0] a, input logic [31:0] b);
      outs_t o;
      string opName;
      o = '0;
      o.valid = 1'b1;
      case (op)
         6'b000000: begin o.regDst = 1; o.regWrite = 1; o.aluOp = 2'b10; end
         6'b100011: begin o.aluSrc = 1; o.memToReg = 1; o.regWrite = 1; o.memRead = 1; end
         6'b101011: begin o.aluSrc = 1; o.memWrite = 1; end
         6'b000100: begin o.branch = 1; o.aluOp = 2'b01; end
         6'b001000: begin o.aluSrc = 1; o.regWrite = 1; end
         6'b000010: o.jump = 1;
         default:   o.aluOp = 2'b11;
      endcase
      opName = "bad";
      if (o.aluOp == 2'b00) opName = "add";
      else if (o.aluOp == 2'b01) opName = "sub";
      else if (o.aluOp == 2'b10) begin
         case (fn)
            6'b100000: opName = "add";
            6'b100010: opName = "sub";
            6'b100100: opName = "and";
            6'b100101: opName = "or";
            6'b100111: opName = "nor";
            6'b101010: opName = "slt";
`ifdef ALU_SHIFT_EN
            6'b000000: opName = "sll";
            6'b000010: opName = "srl";
`endif
            default:   opName = "bad";
         endcase
      end
      case (opName)
         "add": begin o.aluCtrl = 4'b0010; o.result = a + b; end
         "sub": begin o.aluCtrl = 4'b0110; o.result = a - b; end
         "and": begin o.aluCtrl = 4'b0000; o.result = a & b; end
         "or":  begin o.aluCtrl = 4'b0001; o.result = a | b; end
         "nor": begin o.aluCtrl = 4'b1100; o.result = ~(a | b); end
         "slt": begin o.aluCtrl = 4'b0111; o.result = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
         "sll": begin o.aluCtrl = 4'b0011; o.result = a << b[4:0]; end
         "srl": begin o.aluCtrl = 4'b0100; o.result = a >> b[4:0]; end
         default: begin o.aluCtrl = 4'b1111; o.result = 32'd0; end
      endcase
      o.zero = (o.result == 32'd0);
      return o;
   endfunction

   function automatic outs_t observe();
      outs_t o;
      o.valid    = bus.valid_out;
      o.regDst   = bus.reg_dst;
      o.jump     = bus.jump;
      o.branch   = bus.branch;
      o.memRead  = bus.mem_read;
      o.memToReg = bus.mem_to_reg;
      o.memWrite = bus.mem_write;
      o.aluSrc   = bus.alu_src;
      o.regWrite = bus.reg_write;
      o.aluOp    = bus.alu_op;
      o.aluCtrl  = bus.alu_ctrl;
      o.result   = bus.alu_result;
      o.zero     = bus.zero;
      return o;
   endfunction

   // Drive one cycle of stimulus and record what the next edge must produce.
   task automatic applyStimulus(input logic r, input logic v, input logic [5:0] op,
                                input logic [5:0] fn, input logic [31:0] a,
                                input logic [31:0] b, input string tag);
      entry_t e;
      @(negedge clk);
      rst          = r;
      bus.valid_in = v;
      bus.opcode   = op;
      bus.func     = fn;
      bus.src_a    = a;
      bus.src_b    = b;
      if (r) e.exp = '0;
      else if (v) e.exp = refModel(op, fn, a, b);
      else begin
         e.exp = lastOut;
         e.exp.valid = 1'b0;
      end
      lastOut = e.exp;
      e.tag = tag;
      scoreQ.push_back(e);
   endtask

   task automatic checkOutput(input entry_t e);
      outs_t got;
      got = observe();
      testsRun++;
      if (got !== e.exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got v=%b ctl=%b op=%b ac=%b res=%h z=%b, expected v=%b ctl=%b op=%b ac=%b res=%h z=%b",
                  e.tag, got.valid,
                  {got.regDst, got.jump, got.branch, got.memRead, got.memToReg, got.memWrite, got.aluSrc, got.regWrite},
                  got.aluOp, got.aluCtrl, got.result, got.zero, e.exp.valid,
                  {e.exp.regDst, e.exp.jump, e.exp.branch, e.exp.memRead, e.exp.memToReg, e.exp.memWrite, e.exp.aluSrc, e.exp.regWrite},
                  e.exp.aluOp, e.exp.aluCtrl, e.exp.result, e.exp.zero);
      end
   endtask

   initial begin : monitor
      entry_t e;
      forever begin
         @(posedge clk);
         #1;
         if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : driver
      logic [5:0]  opList [7];
      logic [5:0]  fnList [9];
      logic [5:0]  op, fn;
      logic [31:0] a, b;
      logic        r, v;
      opList = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
      fnList = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                 6'b101010, 6'b000000, 6'b000010, 6'b011011};
      lastOut      = '0;
      rst          = 1'b1;
      bus.valid_in = 1'b0;
      bus.opcode   = '0;
      bus.func     = '0;
      bus.src_a    = '0;
      bus.src_b    = '0;

      applyStimulus(1, 1, 6'b000000, 6'b100000, 32'd10, 32'd5, "reset1");
      applyStimulus(1, 1, 6'b000000, 6'b100000, 32'd10, 32'd5, "reset2");
      applyStimulus(0, 1, 6'b000000, 6'b100000, 32'd10, 32'd5, "r_add");
      applyStimulus(0, 1, 6'b000000, 6'b100010, 32'd10, 32'd5, "r_sub");
      applyStimulus(0, 1, 6'b000000, 6'b100100, 32'd10, 32'd5, "r_and");
      applyStimulus(0, 1, 6'b000000, 6'b100101, 32'd10, 32'd5, "r_or");
      applyStimulus(0, 1, 6'b000000, 6'b101010, 32'd10, 32'd5, "r_slt");
      applyStimulus(0, 1, 6'b000000, 6'b100111, 32'd10, 32'd5, "r_nor");
      applyStimulus(0, 1, 6'b000000, 6'b000000, 32'd10, 32'd5, "r_sll");
      applyStimulus(0, 1, 6'b000000, 6'b000010, 32'd10, 32'd5, "r_srl");
      applyStimulus(0, 1, 6'b100011, 6'($urandom), 32'd10, 32'd5, "lw");
      applyStimulus(0, 1, 6'b101011, 6'b000000, 32'd10, 32'd5, "sw");
      applyStimulus(0, 1, 6'b000100, 6'b100000, 32'd7, 32'd7, "beq_eq");
      applyStimulus(0, 1, 6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, "slt_signed");
      applyStimulus(0, 1, 6'b111111, 6'b100000, 32'd10, 32'd5, "invalid_op");
      applyStimulus(0, 1, 6'b001000, 6'b000000, 32'h7FFF_FFFF, 32'd1, "addi_wrap");
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 6'($urandom), 6'($urandom), $urandom, $urandom, "hold");
      applyStimulus(0, 1, 6'b000000, 6'b100000, 32'd1, 32'd2, "before_rst");
      applyStimulus(1, 1, 6'b000000, 6'b100000, 32'd3, 32'd4, "mid_rst");
      applyStimulus(0, 0, 6'b000000, 6'b100000, 32'd3, 32'd4, "post_rst_idle");

      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 39) == 0);
         v  = ($urandom_range(0, 3) != 0);
         op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : opList[$urandom_range(0, 6)];
         fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fnList[$urandom_range(0, 8)];
         a  = $urandom;
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = 32'($urandom_range(0, 40));
            default: b = $urandom;
         endcase
         applyStimulus(r, v, op, fn, a, b, "random");
      end

      applyStimulus(0, 0, 6'b000000, 6'b000000, 32'd0, 32'd0, "final_idle");
      repeat (3) @(negedge clk);
      testsRun++;
      if (scoreQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got %0d pending entries, expected 0", scoreQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
